// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// blank pattern and segment bit positions (bit 0 = a ... bit 6 = g).
package ss_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high glyphs, entry 0 at the least significant position.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_glyph_lut.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module hex_glyph_lut
  import ss_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);

  // Table lookup on the selected nibble.
  always_comb begin
    glyph_o = GLYPH_TABLE[nib_i];
  end

endmodule

// File: rtl/ss_scan_driver.sv
// Time-multiplexed seven-segment driver with guard interval, decimal points,
// leading-zero blanking and frame-synchronous (tear-free) display updates.
module ss_scan_driver
  import ss_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD     = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_INV  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]             pcnt_q, pcnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d, shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d, shd_dp_q, shd_dp_d;
  logic                      pend_blz_q, pend_blz_d, shd_blz_q, shd_blz_d;
  logic                      pend_vld_q, pend_vld_d, shd_vld_q, shd_vld_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      fd_q;

  logic                      tc_s, boundary_s, zero_run_s, lit_s;
  logic [NUM_DIGITS-1:0]     blank_vec_s;
  logic [3:0]                nib_s;
  logic [6:0]                glyph_s;

  // Prescaler, digit index and double-buffered display data.
  always_comb begin
    tc_s       = (pcnt_q == PCNT_LAST);
    boundary_s = tc_s && (idx_q == IDX_LAST);
    pcnt_d     = tc_s ? '0 : pcnt_q + PW'(1);
    if (tc_s) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end else begin
      idx_d = idx_q;
    end
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      pend_blz_d = blank_lz;
      pend_vld_d = 1'b1;
    end else begin
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_blz_d = pend_blz_q;
      pend_vld_d = pend_vld_q;
    end
    // A load coinciding with the boundary bypasses pending straight to shadow.
    if (boundary_s) begin
      shd_val_d = load ? value    : pend_val_q;
      shd_dp_d  = load ? dp_in    : pend_dp_q;
      shd_blz_d = load ? blank_lz : pend_blz_q;
      shd_vld_d = load | pend_vld_q;
    end else begin
      shd_val_d = shd_val_q;
      shd_dp_d  = shd_dp_q;
      shd_blz_d = shd_blz_q;
      shd_vld_d = shd_vld_q;
    end
  end

  // Leading-zero mask, digit selection and polarity-adjusted output values.
  always_comb begin
    zero_run_s  = 1'b1;
    blank_vec_s = '0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      zero_run_s     = zero_run_s & (shd_val_q[4*j +: 4] == 4'h0);
      blank_vec_s[j] = shd_blz_q & zero_run_s & (j != 0);
    end
    nib_s = shd_val_q[int'(idx_q)*4 +: 4];
    lit_s = shd_vld_q && (pcnt_q >= GUARD) && !blank_vec_s[idx_q];
    seg_d = (lit_s ? glyph_s : SEG_BLANK) ^ SEG_INV;
    dp_d  = (lit_s & shd_dp_q[idx_q]) ^ DP_INV;
    if (lit_s) begin
      an_d = (NUM_DIGITS'(1) << idx_q) ^ AN_INV;
    end else begin
      an_d = AN_INV;
    end
  end

  hex_glyph_lut u_lut (
    .nib_i   (nib_s),
    .glyph_o (glyph_s)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_blz_q <= 1'b0;
      pend_vld_q <= 1'b0;
      shd_val_q  <= '0;
      shd_dp_q   <= '0;
      shd_blz_q  <= 1'b0;
      shd_vld_q  <= 1'b0;
      seg_q      <= SEG_INV;
      dp_q       <= DP_INV;
      an_q       <= AN_INV;
      fd_q       <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_blz_q <= pend_blz_d;
      pend_vld_q <= pend_vld_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      shd_blz_q  <= shd_blz_d;
      shd_vld_q  <= shd_vld_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= boundary_s;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. One digit is lit at a time.
- Converts a packed hex word into per-digit segment patterns and cycles digit enables at a programmable refresh rate.
- Adds a ghosting guard interval, decimal points, leading-zero blanking and tear-free frame-synchronous updates.
- Sits between datapath result registers and board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= GUARD_CYCLES+1).
- GUARD_CYCLES, 2, cycles at the start of each slot with all anodes off.
- SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs low-true.
- AN_ACTIVE_LOW, 1, 1 = anode outputs low-true.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  packed hex digits; digit 0 = bits [3:0].
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_lz  in  1  enable leading-zero blanking.
- load  in  1  one-cycle strobe; captures value/dp_in/blank_lz.
- seg  out  7  segments {g,f,e,d,c,b,a}, bit 0 = a.
- dp  out  1  decimal point of the lit digit.
- an  out  NUM_DIGITS  digit enables, one-hot when active.
- frame_done  out  1  one-cycle pulse per completed scan frame.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - All outputs inactive: an all inactive, seg all off, dp off, frame_done 0.
  - Internal state cleared: prescaler 0, digit index 0, pending and shadow registers 0.
- Prescaler pcnt:
  - Counts 0..REFRESH_DIV-1.
  - At terminal count, pcnt returns to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the terminal-count cycle with idx == NUM_DIGITS-1.
  - On this cycle, shadow <= (load ? inputs : pending).
  - frame_done is high during the cycle following the boundary.
- load:
  - On a non-boundary cycle, captures into pending only; the display never changes mid-frame.
  - Multiple loads in one frame: the last one wins.
- Output registers:
  - seg, dp and an are registered from (idx, pcnt, shadow), giving one cycle of latency.
  - an is active for digit idx only when pcnt >= GUARD_CYCLES; otherwise all inactive.
- Glyphs: 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (active-high form). Outputs are inverted when the *_ACTIVE_LOW parameter is 1.
- Leading-zero blanking (shadow blank_lz = 1):
  - Digit k is blanked when it and every more significant digit are 0, except that digit 0 is never blanked.
  - A blanked digit drives its anode inactive and segments off, and dp_in is ignored for it.
- dp = shadow dp bit of idx, gated the same way as an.
- Reset mid-frame takes priority over load and boundary in the same cycle. After reset, no glyph is lit until a load is transferred at a boundary; shadow 0 shows digit 0 as '0'.

Decomposition:
- Shared package ss_pkg holds:
  - the 16-entry glyph constant table;
  - SEG_BLANK = 7'h00;
  - the segment bit-order constants.
- One sub-module, hex_glyph_lut: combinational 4-bit to 7-bit lookup reading the package table. It is instantiated once on the selected nibble.
- Prescaler, index, buffering and output registers live in ss_scan_driver.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, both active-low):
- Reset: assert rst for 3 cycles mid-scan -> an=4'hF, seg=7'h7F, dp=1, frame_done=0 on the next edge; pcnt and idx restart at 0.
- Scan order: load 16'h12AF, then wait for the boundary -> per slot an=1110/1101/1011/0111 with seg=~71,~77,~5B,~06 (0E,08,24,79).
- Guard: in the first cycle of every slot an=4'hF; the next 3 cycles show the one-hot enable. frame_done pulses every 16 cycles exactly.
- Leading zeros: load 16'h0040 with blank_lz=1 -> digits 3 and 2 show an inactive and seg=7'h7F; digit 1 shows seg=7'h19 and digit 0 shows seg=7'h40. Load 16'h0000 -> only digit 0 is lit, showing '0'.
- Tear-free update: load 16'h1111, then 16'h2222 mid-frame -> the current frame stays unchanged; the next frame shows all '2' (seg=7'h24).
- Coincident load at the boundary with 16'h3333 -> the following frame shows '3' (seg=7'h30), not the stale pending value. A dp_in=4'b0100 load gives dp=0 only in the digit-2 slot.
